// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding,
// default debounce settings, auto-repeat multiplier and a one-hot helper.
package condicionador_pkg;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESTABILIZANDO = 2'd1,
    PRESSIONADO   = 2'd2,
    SOLTANDO      = 2'd3
  } estado_t;

  localparam int DEBOUNCE_PADRAO = 50000;
  localparam int LARGURA_PADRAO  = 16;
  localparam int FATOR_REPETICAO = 8;

  // Edges after reset during which s still reflects a button held through reset.
  localparam int ESPERA_SINC = 3;

  function automatic logic eh_unico(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/condicionador_botoes_debounce_canal.sv
// One input channel: 2-flop synchronizer, debounce FSM with saturating
// counter, accepted-value register and a one-cycle pulse on acceptance.
//
// state         | meaning
// OCIOSO        | synchronized input is zero, waiting for a press
// ESTABILIZANDO | nonzero sample captured, counting stable cycles
// PRESSIONADO   | press accepted, value held until it changes
// SOLTANDO      | waiting for a full debounced release (all zeros)
module debounce_canal
  import condicionador_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int LARGURA_CONT    = LARGURA_PADRAO
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] entrada_i,
  output logic [N-1:0] valor_o,
  output logic         pulso_o,
  output estado_t      estado_o
);

  localparam logic [LARGURA_CONT-1:0] CONT_FIM = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;
  localparam logic [1:0]              GUARDA_INI = 2'(ESPERA_SINC);

  logic [N-1:0]            sinc1_q, sinc2_q, amostra_q, valor_q;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic [1:0]              guarda_q;
  estado_t                 estado_q;
  logic                    pulso_q;

  assign cont_d = (cont_q == CONT_MAX) ? cont_q : cont_q + LARGURA_CONT'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1_q   <= '0;
      sinc2_q   <= '0;
      amostra_q <= '0;
      valor_q   <= '0;
      cont_q    <= '0;
      guarda_q  <= GUARDA_INI;
      estado_q  <= OCIOSO;
      pulso_q   <= 1'b0;
    end else begin
      sinc1_q <= entrada_i;
      sinc2_q <= sinc1_q;
      pulso_q <= 1'b0;
      if (guarda_q != 2'd0) guarda_q <= guarda_q - 2'd1;

      case (estado_q)
        OCIOSO: begin
          if (sinc2_q != '0) begin
            amostra_q <= sinc2_q;
            cont_q    <= '0;
            // A button held across reset must be released before it counts.
            estado_q  <= (guarda_q != 2'd0) ? SOLTANDO : ESTABILIZANDO;
          end
        end
        ESTABILIZANDO: begin
          if (sinc2_q != amostra_q) begin
            amostra_q <= sinc2_q;
            cont_q    <= '0;
            if (sinc2_q == '0) estado_q <= OCIOSO;
          end else if (cont_q == CONT_FIM) begin
            estado_q <= PRESSIONADO;
            valor_q  <= amostra_q;
            pulso_q  <= 1'b1;
          end else begin
            cont_q <= cont_d;
          end
        end
        PRESSIONADO: begin
          if (sinc2_q != amostra_q) begin
            cont_q   <= '0;
            estado_q <= SOLTANDO;
          end
        end
        SOLTANDO: begin
          if (sinc2_q != '0) begin
            cont_q <= '0;
          end else if (cont_q == CONT_FIM) begin
            estado_q <= OCIOSO;
            valor_q  <= '0;
          end else begin
            cont_q <= cont_d;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign valor_o  = valor_q;
  assign pulso_o  = pulso_q;
  assign estado_o = estado_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Pushbutton conditioner for the memory game: debounced one-hot play code,
// press pulses and multi-button error. CONDICIONADOR_REPETICAO_EN enables auto-repeat.
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int LARGURA_CONT    = LARGURA_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  input  logic       jogar_in,
  output logic [3:0] botoes_limpos,
  output logic       jogada_pulso,
  output logic       jogar_pulso,
  output logic       erro_multiplo,
  output logic [1:0] db_estado_botoes
);

  logic [3:0] valor_bot;
  logic       pulso_bot;
  estado_t    estado_bot;
  logic [0:0] valor_jog;
  logic       pulso_jog;
  estado_t    estado_jog;
  logic       unico;
  logic       unused_jog;

  debounce_canal #(
    .N               (4),
    .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
    .LARGURA_CONT    (LARGURA_CONT)
  ) u_botoes (
    .clock     (clock),
    .reset     (reset),
    .entrada_i (botoes_in),
    .valor_o   (valor_bot),
    .pulso_o   (pulso_bot),
    .estado_o  (estado_bot)
  );

  debounce_canal #(
    .N               (1),
    .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
    .LARGURA_CONT    (LARGURA_CONT)
  ) u_jogar (
    .clock     (clock),
    .reset     (reset),
    .entrada_i (jogar_in),
    .valor_o   (valor_jog),
    .pulso_o   (pulso_jog),
    .estado_o  (estado_jog)
  );

  assign unused_jog = ^{valor_jog, estado_jog};

  // valor_bot is held from acceptance until the debounced release completes.
  assign unico            = eh_unico(valor_bot);
  assign botoes_limpos    = unico ? valor_bot : 4'd0;
  assign erro_multiplo    = (valor_bot != 4'd0) && !unico;
  assign jogar_pulso      = pulso_jog;
  assign db_estado_botoes = estado_bot;

`ifdef CONDICIONADOR_REPETICAO_EN
  localparam int LARGURA_REP = LARGURA_CONT + 3;
  localparam logic [LARGURA_REP-1:0] REP_FIM =
    LARGURA_REP'(FATOR_REPETICAO * DEBOUNCE_CICLOS - 1);

  logic [LARGURA_REP-1:0] rep_q;
  logic                   rep_pulso_q;

  always_ff @(posedge clock) begin
    if (reset || (estado_bot != PRESSIONADO) || !unico) begin
      rep_q       <= '0;
      rep_pulso_q <= 1'b0;
    end else begin
      rep_pulso_q <= (rep_q == REP_FIM);
      rep_q       <= (rep_q == REP_FIM) ? '0 : rep_q + LARGURA_REP'(1);
    end
  end

  assign jogada_pulso = (pulso_bot & unico) | rep_pulso_q;
`else
  assign jogada_pulso = pulso_bot & unico;
`endif

endmodule
